// File: rtl/rvh_mmu_ptw.sv
// Sv39 page-table walker: one TLB miss at a time, walked through a single PTE read port.
// Optional macro RVH_MMU_PTW_SUPERPAGE_EN accepts aligned 1 GiB / 2 MiB leaves; otherwise they fault.
module rvh_mmu_ptw #(
    parameter int VPN_WIDTH      = 27,
    parameter int TRANS_ID_WIDTH = 3,
    parameter int ASID_WIDTH     = 16,
    parameter int PPN_WIDTH      = 44,
    parameter int PADDR_WIDTH    = 56
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      req_vld_i,
    output logic                      req_rdy_o,
    input  logic [TRANS_ID_WIDTH-1:0] req_trans_id_i,
    input  logic [ASID_WIDTH-1:0]     req_asid_i,
    input  logic [VPN_WIDTH-1:0]      req_vpn_i,
    input  logic [1:0]                req_access_type_i,
    input  logic [PPN_WIDTH-1:0]      satp_ppn_i,
    output logic                      mem_req_vld_o,
    input  logic                      mem_req_rdy_i,
    output logic [PADDR_WIDTH-1:0]    mem_req_paddr_o,
    input  logic                      mem_resp_vld_i,
    input  logic [63:0]               mem_resp_pte_i,
    output logic                      resp_vld_o,
    output logic [TRANS_ID_WIDTH-1:0] resp_trans_id_o,
    output logic [ASID_WIDTH-1:0]     resp_asid_o,
    output logic [VPN_WIDTH-1:0]      resp_vpn_o,
    output logic [1:0]                resp_access_type_o,
    output logic [63:0]               resp_pte_o,
    output logic [1:0]                resp_level_o,
    output logic                      resp_fault_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [TRANS_ID_WIDTH-1:0] trans_id_q, trans_id_d;
    logic [ASID_WIDTH-1:0]     asid_q, asid_d;
    logic [VPN_WIDTH-1:0]      vpn_q, vpn_d;
    logic [1:0]                access_type_q, access_type_d;
    logic [1:0]                level_q, level_d;
    logic [PPN_WIDTH-1:0]      base_q, base_d;
    logic [63:0]               pte_q, pte_d;
    logic                      fault_q, fault_d;

    logic [8:0] vpn_idx;
    logic       pte_v, pte_r, pte_w, pte_x;
    logic       pte_leaf, pte_invalid, leaf_fault;

    always_comb begin
        case (level_q)
            2'd2:    vpn_idx = vpn_q[26:18];
            2'd1:    vpn_idx = vpn_q[17:9];
            default: vpn_idx = vpn_q[8:0];
        endcase
    end

    assign pte_v       = mem_resp_pte_i[0];
    assign pte_r       = mem_resp_pte_i[1];
    assign pte_w       = mem_resp_pte_i[2];
    assign pte_x       = mem_resp_pte_i[3];
    assign pte_invalid = !pte_v || (!pte_r && pte_w);
    assign pte_leaf    = pte_r || pte_x;

    // A leaf above level 0 is a superpage; its low PPN slices must be zero.
    always_comb begin
        leaf_fault = 1'b0;
        if (level_q != 2'd0) begin
`ifdef RVH_MMU_PTW_SUPERPAGE_EN
            leaf_fault = (level_q == 2'd2) ? (|mem_resp_pte_i[27:10])
                                           : (|mem_resp_pte_i[18:10]);
`else
            leaf_fault = 1'b1;
`endif
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        trans_id_d    = trans_id_q;
        asid_d        = asid_q;
        vpn_d         = vpn_q;
        access_type_d = access_type_q;
        level_d       = level_q;
        base_d        = base_q;
        pte_d         = pte_q;
        fault_d       = fault_q;
        req_rdy_o     = 1'b0;
        mem_req_vld_o = 1'b0;
        resp_vld_o    = 1'b0;

        case (state_q)
            IDLE: begin
                req_rdy_o = 1'b1;
                if (req_vld_i) begin
                    trans_id_d    = req_trans_id_i;
                    asid_d        = req_asid_i;
                    vpn_d         = req_vpn_i;
                    access_type_d = req_access_type_i;
                    level_d       = 2'd2;
                    base_d        = satp_ppn_i;
                    fault_d       = 1'b0;
                    state_d       = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_vld_o = 1'b1;
                if (mem_req_rdy_i) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_resp_vld_i) begin
                    pte_d = mem_resp_pte_i;
                    if (pte_invalid) begin
                        fault_d = 1'b1;
                        state_d = RESP;
                    end else if (pte_leaf) begin
                        fault_d = leaf_fault;
                        state_d = RESP;
                    end else if (level_q == 2'd0) begin
                        fault_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        level_d = level_q - 2'd1;
                        base_d  = mem_resp_pte_i[53:10];
                        state_d = MEM_REQ;
                    end
                end
            end
            RESP: begin
                resp_vld_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q       <= IDLE;
            trans_id_q    <= '0;
            asid_q        <= '0;
            vpn_q         <= '0;
            access_type_q <= '0;
            level_q       <= '0;
            base_q        <= '0;
            pte_q         <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            trans_id_q    <= trans_id_d;
            asid_q        <= asid_d;
            vpn_q         <= vpn_d;
            access_type_q <= access_type_d;
            level_q       <= level_d;
            base_q        <= base_d;
            pte_q         <= pte_d;
            fault_q       <= fault_d;
        end
    end

    assign mem_req_paddr_o    = {base_q, vpn_idx, 3'b000};
    assign resp_trans_id_o    = trans_id_q;
    assign resp_asid_o        = asid_q;
    assign resp_vpn_o         = vpn_q;
    assign resp_access_type_o = access_type_q;
    assign resp_pte_o         = pte_q;
    assign resp_level_o       = level_q;
    assign resp_fault_o       = fault_q;

endmodule

// File: tb/tb_rvh_mmu_ptw.sv
// Directed bench for rvh_mmu_ptw: the bench plays the memory and checks every walk step.
// Expectations for the 1 GiB leaf follow RVH_MMU_PTW_SUPERPAGE_EN like the design.
module tb_rvh_mmu_ptw;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_vld_i;
    logic        req_rdy_o;
    logic [2:0]  req_trans_id_i;
    logic [15:0] req_asid_i;
    logic [26:0] req_vpn_i;
    logic [1:0]  req_access_type_i;
    logic [43:0] satp_ppn_i;
    logic        mem_req_vld_o;
    logic        mem_req_rdy_i;
    logic [55:0] mem_req_paddr_o;
    logic        mem_resp_vld_i;
    logic [63:0] mem_resp_pte_i;
    logic        resp_vld_o;
    logic [2:0]  resp_trans_id_o;
    logic [15:0] resp_asid_o;
    logic [26:0] resp_vpn_o;
    logic [1:0]  resp_access_type_o;
    logic [63:0] resp_pte_o;
    logic [1:0]  resp_level_o;
    logic        resp_fault_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] cur_asid;
    logic [26:0] cur_vpn;
    logic [1:0]  cur_at;

    rvh_mmu_ptw dut (
        .clk                (clk),
        .rstn               (rstn),
        .req_vld_i          (req_vld_i),
        .req_rdy_o          (req_rdy_o),
        .req_trans_id_i     (req_trans_id_i),
        .req_asid_i         (req_asid_i),
        .req_vpn_i          (req_vpn_i),
        .req_access_type_i  (req_access_type_i),
        .satp_ppn_i         (satp_ppn_i),
        .mem_req_vld_o      (mem_req_vld_o),
        .mem_req_rdy_i      (mem_req_rdy_i),
        .mem_req_paddr_o    (mem_req_paddr_o),
        .mem_resp_vld_i     (mem_resp_vld_i),
        .mem_resp_pte_i     (mem_resp_pte_i),
        .resp_vld_o         (resp_vld_o),
        .resp_trans_id_o    (resp_trans_id_o),
        .resp_asid_o        (resp_asid_o),
        .resp_vpn_o         (resp_vpn_o),
        .resp_access_type_o (resp_access_type_o),
        .resp_pte_o         (resp_pte_o),
        .resp_level_o       (resp_level_o),
        .resp_fault_o       (resp_fault_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] tid, input logic [15:0] asid, input logic [26:0] vpn,
                         input logic [1:0] at, input logic [43:0] satp);
        check("req_rdy_before_accept", {63'd0, req_rdy_o}, 64'd1);
        cur_asid = asid;
        cur_vpn  = vpn;
        cur_at   = at;
        req_vld_i = 1'b1;
        req_trans_id_i = tid;
        req_asid_i = asid;
        req_vpn_i = vpn;
        req_access_type_i = at;
        satp_ppn_i = satp;
        tick();
        req_vld_i  = 1'b0;
        satp_ppn_i = 44'h0;
        check("req_rdy_after_accept", {63'd0, req_rdy_o}, 64'd0);
    endtask

    // One PTE read: address check, handshake, then one cycle of response data.
    task automatic serve(input string tag, input logic [55:0] exp_addr, input logic [63:0] pte);
        check({tag, "_mem_req_vld"}, {63'd0, mem_req_vld_o}, 64'd1);
        check({tag, "_paddr"}, {8'd0, mem_req_paddr_o}, {8'd0, exp_addr});
        mem_req_rdy_i = 1'b1;
        tick();
        mem_req_rdy_i = 1'b0;
        check({tag, "_wait_no_req"}, {63'd0, mem_req_vld_o}, 64'd0);
        mem_resp_vld_i = 1'b1;
        mem_resp_pte_i = pte;
        tick();
        mem_resp_vld_i = 1'b0;
        mem_resp_pte_i = 64'h0;
    endtask

    task automatic expect_resp(input string tag, input logic [2:0] tid, input logic [1:0] level,
                               input logic fault, input logic [63:0] pte);
        check({tag, "_resp_vld"}, {63'd0, resp_vld_o}, 64'd1);
        check({tag, "_no_extra_read"}, {63'd0, mem_req_vld_o}, 64'd0);
        check({tag, "_trans_id"}, {61'd0, resp_trans_id_o}, {61'd0, tid});
        check({tag, "_level"}, {62'd0, resp_level_o}, {62'd0, level});
        check({tag, "_fault"}, {63'd0, resp_fault_o}, {63'd0, fault});
        check({tag, "_pte"}, resp_pte_o, pte);
        check({tag, "_asid"}, {48'd0, resp_asid_o}, {48'd0, cur_asid});
        check({tag, "_vpn"}, {37'd0, resp_vpn_o}, {37'd0, cur_vpn});
        check({tag, "_access_type"}, {62'd0, resp_access_type_o}, {62'd0, cur_at});
        tick();
        check({tag, "_resp_one_cycle"}, {63'd0, resp_vld_o}, 64'd0);
        check({tag, "_rdy_after_resp"}, {63'd0, req_rdy_o}, 64'd1);
    endtask

    initial begin
        rstn = 1'b1;
        req_vld_i = 1'b0;
        req_trans_id_i = '0;
        req_asid_i = '0;
        req_vpn_i = '0;
        req_access_type_i = '0;
        satp_ppn_i = '0;
        mem_req_rdy_i = 1'b0;
        mem_resp_vld_i = 1'b0;
        mem_resp_pte_i = '0;
        cur_asid = '0;
        cur_vpn = '0;
        cur_at = '0;
        tick();
        tick();
        rstn = 1'b0;
        tick();

        check("reset_req_rdy", {63'd0, req_rdy_o}, 64'd1);
        check("reset_mem_req_vld", {63'd0, mem_req_vld_o}, 64'd0);
        check("reset_resp_vld", {63'd0, resp_vld_o}, 64'd0);
        check("reset_resp_pte", resp_pte_o, 64'd0);
        check("reset_resp_trans_id", {61'd0, resp_trans_id_o}, 64'd0);

        // Three-level walk: vpn 0x0201003 -> indices 8 / 8 / 3; pointers 0x200 then 0x300.
        issue(3'd5, 16'hBEEF, 27'h0201003, 2'd1, 44'h100);
        serve("w3_l2", 56'h100040, 64'h80001);
        serve("w3_l1", 56'h200040, 64'hC0001);
        serve("w3_l0", 56'h300018, 64'h48D14CF);
        expect_resp("w3", 3'd5, 2'd0, 1'b0, 64'h48D14CF);

        // 1 GiB leaf at level 2: vpn[26:18] = 0x30, PPN 0x40000 has PPN[17:0] = 0.
        issue(3'd2, 16'h0001, 27'h0C00000, 2'd2, 44'h100);
        serve("gib", 56'h100180, 64'h100000CF);
`ifdef RVH_MMU_PTW_SUPERPAGE_EN
        expect_resp("gib", 3'd2, 2'd2, 1'b0, 64'h100000CF);
`else
        expect_resp("gib", 3'd2, 2'd2, 1'b1, 64'h100000CF);
`endif

        // Misaligned 2 MiB leaf: PPN 0x401 has PPN[8:0] = 1; faults after two reads.
        issue(3'd3, 16'h1234, 27'h0201003, 2'd0, 44'h100);
        serve("mis_l2", 56'h100040, 64'h80001);
        serve("mis_l1", 56'h200040, 64'h1004CF);
        expect_resp("mis", 3'd3, 2'd1, 1'b1, 64'h1004CF);

        // Level-1 PTE with V = 0: fault, no third read.
        issue(3'd4, 16'h0042, 27'h0201003, 2'd3, 44'h100);
        serve("inv_l2", 56'h100040, 64'h80001);
        serve("inv_l1", 56'h200040, 64'h80000);
        expect_resp("inv", 3'd4, 2'd1, 1'b1, 64'h80000);

        // Pointer returned at level 0 faults.
        issue(3'd1, 16'h0007, 27'h0201003, 2'd1, 44'h100);
        serve("ptr0_l2", 56'h100040, 64'h80001);
        serve("ptr0_l1", 56'h200040, 64'hC0001);
        serve("ptr0_l0", 56'h300018, 64'h100001);
        expect_resp("ptr0", 3'd1, 2'd0, 1'b1, 64'h100001);

        // Memory stall: request held five cycles, then a W-without-R PTE faults at level 2.
        issue(3'd7, 16'hAAAA, 27'h0201003, 2'd0, 44'h100);
        for (int i = 0; i < 5; i++) begin
            check("stall_mem_req_vld", {63'd0, mem_req_vld_o}, 64'd1);
            check("stall_paddr", {8'd0, mem_req_paddr_o}, 64'h100040);
            check("stall_req_rdy", {63'd0, req_rdy_o}, 64'd0);
            tick();
        end
        serve("stall_l2", 56'h100040, 64'h5);
        expect_resp("stall", 3'd7, 2'd2, 1'b1, 64'h5);

        // Reset while waiting for memory, then a stale response arrives.
        issue(3'd6, 16'h5555, 27'h0201003, 2'd2, 44'h100);
        check("rst_mem_req_vld", {63'd0, mem_req_vld_o}, 64'd1);
        mem_req_rdy_i = 1'b1;
        tick();
        mem_req_rdy_i = 1'b0;
        rstn = 1'b1;
        #1;
        check("rst_async_req_rdy", {63'd0, req_rdy_o}, 64'd1);
        check("rst_async_mem_req_vld", {63'd0, mem_req_vld_o}, 64'd0);
        tick();
        rstn = 1'b0;
        mem_resp_vld_i = 1'b1;
        mem_resp_pte_i = 64'h48D14CF;
        tick();
        mem_resp_vld_i = 1'b0;
        mem_resp_pte_i = 64'h0;
        check("stale_resp_vld", {63'd0, resp_vld_o}, 64'd0);
        check("stale_req_rdy", {63'd0, req_rdy_o}, 64'd1);
        check("stale_mem_req_vld", {63'd0, mem_req_vld_o}, 64'd0);
        tick();
        check("stale_resp_vld_late", {63'd0, resp_vld_o}, 64'd0);

        issue(3'd6, 16'h5555, 27'h0201003, 2'd2, 44'h100);
        serve("post_l2", 56'h100040, 64'h80001);
        serve("post_l1", 56'h200040, 64'hC0001);
        serve("post_l0", 56'h300018, 64'h48D14CF);
        expect_resp("post", 3'd6, 2'd0, 1'b0, 64'h48D14CF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rvh_mmu_ptw.md
# rvh_mmu_ptw

Sv39 page-table walker serving TLB-miss requests issued by the MMU miss-status holding registers. It accepts one miss (trans_id, ASID, VPN, access type) at a time and walks the page table through a single memory read port. When the walk ends it returns a one-cycle response tagged with the original trans_id, which deallocates the matching miss entry and refills the TLB. It sits between the MMU miss tracking and the D-cache/L2 read port.

## Interface
- VPN_WIDTH, 27, virtual page number width (3 × 9).
- TRANS_ID_WIDTH, 3, miss transaction id width.
- ASID_WIDTH, 16, address-space id width.
- PPN_WIDTH, 44, physical page number width.
- PADDR_WIDTH, 56, physical address width; must equal PPN_WIDTH + 12.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset; one clock, asynchronous, active-high (1 = in reset).
- req_vld_i  input  1  miss request valid.
- req_rdy_o  output  1  walker idle and able to accept.
- req_trans_id_i  input  TRANS_ID_WIDTH  miss id.
- req_asid_i  input  ASID_WIDTH  ASID.
- req_vpn_i  input  VPN_WIDTH  VPN.
- req_access_type_i  input  2  access type; echoed back.
- satp_ppn_i  input  PPN_WIDTH  root table PPN; sampled on accept.
- mem_req_vld_o  output  1  PTE read request valid.
- mem_req_rdy_i  input  1  memory accepts request.
- mem_req_paddr_o  output  PADDR_WIDTH  PTE address.
- mem_resp_vld_i  input  1  PTE data valid.
- mem_resp_pte_i  input  64  PTE data.
- resp_vld_o  output  1  walk result, one-cycle pulse, no backpressure.
- resp_trans_id_o  output  TRANS_ID_WIDTH  id of the completed miss.
- resp_asid_o / resp_vpn_o / resp_access_type_o  output  ASID_WIDTH / VPN_WIDTH / 2  echoed request fields.
- resp_pte_o  output  64  final PTE.
- resp_level_o  output  2  level at which the walk ended (2 = 1 GiB, 1 = 2 MiB, 0 = 4 KiB).
- resp_fault_o  output  1  page fault.

## Operation
- FSM states: IDLE, MEM_REQ, MEM_WAIT, RESP.
- req_rdy_o = (state == IDLE).
- IDLE:
  - On req_vld_i, latch all request fields.
  - Set level = 2 and base = satp_ppn_i.
  - Go to MEM_REQ.
- MEM_REQ:
  - mem_req_vld_o = 1.
  - mem_req_paddr_o = {base, vpn[level*9 +: 9], 3'b000}.
  - On mem_req_rdy_i, go to MEM_WAIT.
- MEM_WAIT: on mem_resp_vld_i, latch the PTE and decode it:
  - V = 0, or (R = 0 and W = 1): fault → RESP.
  - Leaf (R or X set): success → RESP, except when level > 0 and PTE.PPN[level*9-1:0] ≠ 0 (misaligned superpage), which faults.
  - Pointer (R = X = 0):
    - At level 0: fault → RESP.
    - Otherwise: level − 1, base = PTE[53:10], back to MEM_REQ.
- RESP:
  - resp_vld_o = 1 for exactly one cycle.
  - resp_level_o = current level; resp_pte_o = last PTE.
  - On fault, resp_pte_o holds the faulting PTE.
  - Go to IDLE.
- mem_resp_vld_i outside MEM_WAIT is ignored.
- No permission or A/D checking against the access type; it is echoed back only.

## Timing
- Reset values:
  - state = IDLE, so req_rdy_o = 1.
  - mem_req_vld_o = 0, resp_vld_o = 0.
  - All latched data = 0.
- Latency:
  - Accept at cycle T; mem_req_vld_o from T+1.
  - resp_vld_o is asserted in the cycle after the terminating mem_resp_vld_i.
  - Best 3-level walk: 3 × (1 + memory latency) + 2 cycles.
- mem_req_paddr_o is held stable while mem_req_vld_o = 1 and mem_req_rdy_i = 0.
- req_rdy_o is low from the cycle after accept until the cycle after resp_vld_o. There is no back-to-back accept in the RESP cycle.
- Reset asserted mid-walk:
  - Immediate return to IDLE and all valids drop.
  - A memory response still in flight is later ignored, because the walker is not in MEM_WAIT.

## Configuration
- RVH_MMU_PTW_SUPERPAGE_EN:
  - Defined: leaf PTEs at levels 2 and 1 are accepted, subject to the alignment check.
  - Undefined: any leaf at level > 0 raises resp_fault_o, and only 4 KiB pages refill.

## Test plan
- 3-level walk: satp_ppn = 0x100, vpn = 0x0_0201_003. Expected memory reads:
  - 0x100000 + 8 × vpn[26:18].
  - Then 8 × vpn[17:9] under pointer PPN 0x200.
  - Then 8 × vpn[8:0] under pointer PPN 0x300.

  Level-0 leaf PTE 0x...CF → resp_vld for 1 cycle with trans_id = 5, level = 0, fault = 0.
- 1 GiB leaf at level 2 with PPN[17:0] = 0:
  - With the macro: level = 2, fault = 0.
  - Without the macro: fault = 1.
- Misaligned 2 MiB leaf (PPN[8:0] = 1) → fault = 1, level = 1, exactly 2 memory reads.
- Level-1 PTE with V = 0 → fault = 1 and no third read. Pointer at level 0 → fault = 1.
- Hold mem_req_rdy_i = 0 for 5 cycles → mem_req_vld_o and paddr stable throughout, req_rdy_o = 0, exactly one request fires.
- Assert reset while in MEM_WAIT, then deliver a stale mem_resp_vld_i → no resp_vld_o, req_rdy_o = 1, and the next request walks correctly.
